byte_stream_packer: RTL

//  Downstream of the merger stage. Consumes the merger's variable-length, MSB-left-aligned

---
 rtl/byte_stream_packer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/byte_stream_packer.sv
// Packs variable-length, left-aligned byte chunks into fixed OUT_WIDTH words with flush/drain.
// Define BSP_LEN_CHECK_EN to add the sticky lenErr output for oversize inLen.
module byte_stream_packer #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 64,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wrtEn,
    output logic                 inReady,
    input  logic [IN_WIDTH-1:0]  dataIn,
    input  logic [LEN_WIDTH-1:0] inLen,
    input  logic                 flush,
    output logic [OUT_WIDTH-1:0] dataOut,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [LEN_WIDTH-1:0] outBytes,
`ifdef BSP_LEN_CHECK_EN
    output logic                 lenErr,
`endif
    output logic                 outLast
);

    localparam int IN_BYTES  = IN_WIDTH / 8;
    localparam int OUT_BYTES = OUT_WIDTH / 8;
    localparam int BUF_BYTES = 2 * OUT_BYTES;
    localparam int BUF_WIDTH = 8 * BUF_BYTES;
    localparam int FILL_W    = $clog2(BUF_BYTES + 1);

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_LAST} state_e;

    state_e                 state_q, state_d;
    logic [BUF_WIDTH-1:0]   buf_q, buf_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [OUT_WIDTH-1:0]   data_out_q, data_out_d;
    logic                   out_valid_q, out_valid_d;
    logic [LEN_WIDTH-1:0]   out_bytes_q, out_bytes_d;
    logic                   out_last_q, out_last_d;

    logic                   len_over;
    logic [LEN_WIDTH-1:0]   len_clamped;
    logic [IN_WIDTH-1:0]    chunk_masked;
    logic                   accept;
    logic                   pop;

    assign inReady = (state_q == S_RUN) &&
                     ({1'b0, fill_q} + (FILL_W+1)'(IN_BYTES) <= (FILL_W+1)'(BUF_BYTES));

    assign accept = wrtEn && inReady;
    assign pop    = out_valid_q && outReady;

    // Bytes past the valid length are forced to zero so appending can use a plain OR.
    assign len_over     = inLen > LEN_WIDTH'(IN_BYTES);
    assign len_clamped  = len_over ? LEN_WIDTH'(IN_BYTES) : inLen;
    assign chunk_masked = dataIn & ~({IN_WIDTH{1'b1}} >> {len_clamped, 3'b000});

    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch is inferred.
        state_d = state_q;
        buf_d   = buf_q;
        fill_d  = fill_q;

        case (state_q)
            S_RUN, S_FLUSH: begin
                if (pop) begin
                    buf_d  = buf_q << OUT_WIDTH;
                    fill_d = fill_q - FILL_W'(OUT_BYTES);
                end
                if (accept) begin
                    buf_d  = buf_d | ({chunk_masked, {(BUF_WIDTH-IN_WIDTH){1'b0}}} >> {fill_d, 3'b000});
                    fill_d = fill_d + FILL_W'(len_clamped);
                end
                if (state_q == S_RUN && flush) begin
                    state_d = S_FLUSH;
                end else if (state_q == S_FLUSH && fill_q < FILL_W'(OUT_BYTES)) begin
                    state_d = S_LAST;
                end
            end
            S_LAST: begin
                if (pop) begin
                    buf_d   = '0;
                    fill_d  = '0;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase

        // Outputs are decoded from next state so they leave the flops already registered.
        data_out_d = buf_d[BUF_WIDTH-1 -: OUT_WIDTH];
        if (state_d == S_LAST) begin
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            out_bytes_d = LEN_WIDTH'(fill_d);
        end else begin
            out_valid_d = fill_d >= FILL_W'(OUT_BYTES);
            out_last_d  = 1'b0;
            out_bytes_d = out_valid_d ? LEN_WIDTH'(OUT_BYTES) : '0;
        end
    end

    // NOTE: the byte buffer is reset too, since LAST relies on bytes past fill being zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_RUN;
            buf_q       <= '0;
            fill_q      <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            out_bytes_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            buf_q       <= buf_d;
            fill_q      <= fill_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            out_bytes_q <= out_bytes_d;
            out_last_q  <= out_last_d;
        end
    end

    assign dataOut  = data_out_q;
    assign outValid = out_valid_q;
    assign outBytes = out_bytes_q;
    assign outLast  = out_last_q;

`ifdef BSP_LEN_CHECK_EN
    logic len_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_err_q <= 1'b0;
        end else if (accept && len_over) begin
            len_err_q <= 1'b1;
        end
    end

    assign lenErr = len_err_q;
`else
    logic unused_len_over;
    assign unused_len_over = len_over;
`endif

endmodule
